m2_rx_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream word-write port among several serial-receive decoder channels. Each decoder produces a 16-bit word and a one-cycle `rden` strobe. This block captures each word into a per-channel holding register and forwards it with its channel index over a valid/ready write interface, typically into the command FIFO. It also flags per-channel overruns and, optionally, line silence.

---
 rtl/m2_rx_arbiter.sv | 130 +++++++++++++
 tb/tb_m2_rx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_rx_arbiter.sv
// m2_rx_arbiter: round-robin merge of NCH decoder word strobes onto one valid/ready write port.
// Define M2_RX_ARB_TIMEOUT_EN to build the per-channel line-silence counters.
module m2_rx_arbiter #(
  parameter int NCH         = 4,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic              clock_system,
  input  logic              rst,
  input  logic [NCH-1:0]    rden_in,
  input  logic [NCH*DW-1:0] recv_data_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [DW-1:0]     wr_data,
  output logic [1:0]        wr_chan,
  output logic [NCH-1:0]    ovf,
  input  logic              ovf_clr,
  output logic [NCH-1:0]    timeout
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [DW-1:0]    hold_data [NCH];
  logic [NCH-1:0]   hold_vld;
  logic [1:0]       last_grant;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic             do_grant;
  logic [NCH-1:0]   grant_mask;
  logic [NCH-1:0]   hold_cap;
  logic [NCH-1:0]   ovf_set;

  // Scan from farthest to nearest candidate so the one right after last_grant is written last and wins.
  always_comb begin : rr_search
    logic [1:0] cand;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = 2'((int'(last_grant) + k) % NCH);
      if (hold_vld[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // NOTE: combinational logic uses blocking '='; only the clocked blocks below use '<='.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          do_grant = 1'b1;
          state_d  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (wr_ready) begin
          do_grant = grant_any;
          state_d  = grant_any ? S_PRESENT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_mask = do_grant ? ({{(NCH-1){1'b0}}, 1'b1} << grant_idx) : '0;
  // A hold being emptied into the output register this cycle may take a new word without overrun.
  assign hold_cap   = rden_in & (~hold_vld | grant_mask);
  assign ovf_set    = rden_in & hold_vld & ~grant_mask;
  assign wr_en      = (state_q == S_PRESENT);

  always_ff @(posedge clock_system) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_vld   <= '0;
      last_grant <= 2'(NCH - 1);
      wr_data    <= '0;
      wr_chan    <= '0;
      ovf        <= '0;
    end else begin
      state_q  <= state_d;
      hold_vld <= (hold_vld & ~grant_mask) | hold_cap;
      ovf      <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
      if (do_grant) begin
        wr_data    <= hold_data[grant_idx];
        wr_chan    <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

  // NOTE: the hold data array is qualified by hold_vld, so it carries no reset.
  always_ff @(posedge clock_system) begin
    for (int i = 0; i < NCH; i++) begin
      if (hold_cap[i]) hold_data[i] <= recv_data_in[i*DW +: DW];
    end
  end

`ifdef M2_RX_ARB_TIMEOUT_EN
  logic [15:0] silence_cnt [NCH];

  always_ff @(posedge clock_system) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) silence_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rden_in[i])                   silence_cnt[i] <= '0;
        else if (silence_cnt[i] != TO_LIM) silence_cnt[i] <= silence_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    timeout = '0;
    for (int i = 0; i < NCH; i++) timeout[i] = (silence_cnt[i] == TO_LIM);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_LIM;
  assign timeout            = '0;
`endif

endmodule

// File: tb/tb_m2_rx_arbiter.sv
// tb_m2_rx_arbiter: vector table, directed corner sequences and a randomized run against a
// transaction-level reference model of the round-robin arbiter.
module tb_m2_rx_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int TO  = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    rden_in = '0;
  logic [NCH*DW-1:0] recv_data_in = '0;
  logic              wr_ready = 1'b0;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_chan;
  logic [NCH-1:0]    ovf;
  logic              ovf_clr = 1'b0;
  logic [NCH-1:0]    timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  m2_rx_arbiter #(.NCH(NCH), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clock_system(clk),
    .rst(rst),
    .rden_in(rden_in),
    .recv_data_in(recv_data_in),
    .wr_ready(wr_ready),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_chan(wr_chan),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && wr_en && wr_ready) wr_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        rst;
    logic [3:0]  rden;
    logic [63:0] data;
    logic        exp_en;
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] rd, input logic [63:0] d,
                              input logic en, input logic [1:0] ch, input logic [15:0] wd);
    vec_t v;
    v.rst = r; v.rden = rd; v.data = d; v.exp_en = en; v.exp_chan = ch; v.exp_data = wd;
    return v;
  endfunction

  vec_t vecs [17];

  // ---------------- reference model ----------------
  logic [NCH-1:0] m_vld;
  logic [DW-1:0]  m_hold [NCH];
  logic           m_present;
  logic [DW-1:0]  m_data;
  logic [1:0]     m_chan;
  int             m_last;
  logic [NCH-1:0] m_ovf;

  task automatic model_step(input logic r, input logic [NCH-1:0] rd, input logic [NCH*DW-1:0] d,
                            input logic rdy, input logic clr);
    bit found;
    int c;
    if (r) begin
      m_vld = '0; m_present = 1'b0; m_data = '0; m_chan = '0; m_last = NCH - 1; m_ovf = '0;
      return;
    end
    // The output register can take a new word if empty or its word leaves this edge.
    if (!m_present || rdy) begin
      found = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (!found && m_vld[c]) begin
          found = 1'b1;
          m_data = m_hold[c];
          m_chan = 2'(c);
          m_vld[c] = 1'b0;
          m_last = c;
        end
      end
      m_present = found;
    end
    if (clr) m_ovf = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (rd[ch]) begin
        if (m_vld[ch]) m_ovf[ch] = 1'b1;
        else begin
          m_vld[ch]  = 1'b1;
          m_hold[ch] = d[ch*DW +: DW];
        end
      end
    end
  endtask

  initial begin
    int base;

    vecs[0]  = mk(1'b1, 4'b0000, 64'h0,                   1'b0, 2'd0, 16'h0);
    vecs[1]  = mk(1'b0, 4'b0100, 64'h0000_A5C3_0000_0000, 1'b0, 2'd0, 16'h0);
    vecs[2]  = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd2, 16'hA5C3);
    vecs[3]  = mk(1'b0, 4'b0000, 64'h0,                   1'b0, 2'd0, 16'h0);
    vecs[4]  = mk(1'b1, 4'b0000, 64'h0,                   1'b0, 2'd0, 16'h0);
    vecs[5]  = mk(1'b0, 4'b1111, 64'h0003_0002_0001_0000, 1'b0, 2'd0, 16'h0);
    vecs[6]  = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd0, 16'h0000);
    vecs[7]  = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd1, 16'h0001);
    vecs[8]  = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd2, 16'h0002);
    vecs[9]  = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd3, 16'h0003);
    vecs[10] = mk(1'b0, 4'b0000, 64'h0,                   1'b0, 2'd0, 16'h0);
    vecs[11] = mk(1'b0, 4'b1111, 64'h0013_0012_0011_0010, 1'b0, 2'd0, 16'h0);
    vecs[12] = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd0, 16'h0010);
    vecs[13] = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd1, 16'h0011);
    vecs[14] = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd2, 16'h0012);
    vecs[15] = mk(1'b0, 4'b0000, 64'h0,                   1'b1, 2'd3, 16'h0013);
    vecs[16] = mk(1'b0, 4'b0000, 64'h0,                   1'b0, 2'd0, 16'h0);

    #1;
    tick();
    wr_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; rden_in = vecs[i].rden; recv_data_in = vecs[i].data;
      tick();
      check($sformatf("vec%0d wr_en", i), 64'(wr_en), 64'(vecs[i].exp_en));
      check($sformatf("vec%0d ovf", i), 64'(ovf), 64'h0);
      if (vecs[i].exp_en) begin
        check($sformatf("vec%0d wr_chan", i), 64'(wr_chan), 64'(vecs[i].exp_chan));
        check($sformatf("vec%0d wr_data", i), 64'(wr_data), 64'(vecs[i].exp_data));
      end
      if (vecs[i].rst) begin
        check($sformatf("vec%0d reset wr_data", i), 64'(wr_data), 64'h0);
        check($sformatf("vec%0d reset wr_chan", i), 64'(wr_chan), 64'h0);
      end
    end
    rden_in = '0;

    // Backpressure: output word held stable, exactly one write after release.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_ready = 1'b0; rden_in = 4'b0010; recv_data_in = 64'h0000_0000_BEEF_0000;
    tick(); rden_in = '0;
    tick();
    check("bp present wr_en", 64'(wr_en), 64'h1);
    check("bp present wr_chan", 64'(wr_chan), 64'h1);
    base = wr_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp stall%0d wr_en", i), 64'(wr_en), 64'h1);
      check($sformatf("bp stall%0d wr_data", i), 64'(wr_data), 64'hBEEF);
    end
    wr_ready = 1'b1;
    tick();
    check("bp released wr_en", 64'(wr_en), 64'h0);
    tick(); tick();
    check("bp write count", 64'(wr_count - base), 64'h1);

    // Overrun: ch1 occupies the output register, ch0 hold fills and then overruns.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_ready = 1'b0; rden_in = 4'b0010; recv_data_in = 64'h0000_0000_7777_0000;
    tick(); rden_in = '0;
    tick();
    check("ovr ch1 presented", 64'(wr_chan), 64'h1);
    rden_in = 4'b0001; recv_data_in = 64'h0000_0000_0000_1111;
    tick();
    check("ovr first word no ovf", 64'(ovf), 64'h0);
    recv_data_in = 64'h0000_0000_0000_2222;
    tick();
    check("ovr flag set", 64'(ovf), 64'h1);
    ovf_clr = 1'b1; recv_data_in = 64'h0000_0000_0000_3333;
    tick();
    check("ovr set wins over clear", 64'(ovf), 64'h1);
    rden_in = '0;
    tick();
    check("ovr cleared", 64'(ovf), 64'h0);
    ovf_clr = 1'b0; wr_ready = 1'b1;
    tick();
    check("ovr next wr_en", 64'(wr_en), 64'h1);
    check("ovr next wr_chan", 64'(wr_chan), 64'h0);
    check("ovr kept old word", 64'(wr_data), 64'h1111);
    tick();
    check("ovr drained", 64'(wr_en), 64'h0);

    // Reset mid-transfer with holds still valid.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_ready = 1'b0; rden_in = 4'b1111; recv_data_in = 64'h4444_3333_2222_1111;
    tick(); rden_in = '0;
    tick();
    check("rstmid presenting", 64'(wr_en), 64'h1);
    rst = 1'b1;
    tick();
    check("rstmid wr_en", 64'(wr_en), 64'h0);
    check("rstmid wr_data", 64'(wr_data), 64'h0);
    check("rstmid wr_chan", 64'(wr_chan), 64'h0);
    check("rstmid ovf", 64'(ovf), 64'h0);
    check("rstmid timeout", 64'(timeout), 64'h0);
    rst = 1'b0; wr_ready = 1'b1;
    base = wr_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rstmid after%0d wr_en", i), 64'(wr_en), 64'h0);
    end
    check("rstmid no stale write", 64'(wr_count - base), 64'h0);

    // Silence timeout.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    check("to before limit", 64'(timeout), 64'h0);
    tick();
`ifdef M2_RX_ARB_TIMEOUT_EN
    check("to at limit", 64'(timeout), 64'hF);
`else
    check("to tied low", 64'(timeout), 64'h0);
`endif
    rden_in = 4'b1000; recv_data_in = 64'h5555_0000_0000_0000;
    tick(); rden_in = '0;
`ifdef M2_RX_ARB_TIMEOUT_EN
    check("to cleared by strobe", 64'(timeout), 64'h7);
`else
    check("to still low", 64'(timeout), 64'h0);
`endif

    // Randomized run against the reference model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst          = (cyc == 0) || ($urandom_range(0, 299) == 0);
      rden_in      = 4'($urandom) & 4'($urandom);
      recv_data_in = {$urandom, $urandom};
      wr_ready     = ($urandom_range(0, 3) != 0);
      ovf_clr      = ($urandom_range(0, 19) == 0);
      tick();
      model_step(rst, rden_in, recv_data_in, wr_ready, ovf_clr);
      check($sformatf("rnd%0d wr_en", cyc), 64'(wr_en), 64'(m_present));
      check($sformatf("rnd%0d ovf", cyc), 64'(ovf), 64'(m_ovf));
      if (m_present) begin
        check($sformatf("rnd%0d wr_chan", cyc), 64'(wr_chan), 64'(m_chan));
        check($sformatf("rnd%0d wr_data", cyc), 64'(wr_data), 64'(m_data));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
